// File: rtl/key_event_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_event_pkg - channel state encoding and counter width helper
// Revision: 1.0
// ----------------------------------------------------------------------------
package key_event_pkg;

  localparam logic [1:0] RELEASED    = 2'd0;
  localparam logic [1:0] PRESS_CHK   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] RELEASE_CHK = 2'd3;

  typedef enum logic [1:0] {
    ST_RELEASED    = RELEASED,
    ST_PRESS_CHK   = PRESS_CHK,
    ST_HELD        = HELD,
    ST_RELEASE_CHK = RELEASE_CHK
  } key_state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_bank_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_event_bank_if - raw key inputs and conditioned event outputs
// Revision: 1.0
// ----------------------------------------------------------------------------
interface key_event_bank_if #(
  parameter int N_KEYS = 8
);

  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] repeat_en;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_posedge;
  logic [N_KEYS-1:0] key_negedge;
  logic [N_KEYS-1:0] key_long;
  logic [N_KEYS-1:0] key_repeat;
  logic              key_any;

  modport master (
    output key_in, repeat_en,
    input  key_level, key_posedge, key_negedge, key_long, key_repeat, key_any
  );

  modport slave (
    input  key_in, repeat_en,
    output key_level, key_posedge, key_negedge, key_long, key_repeat, key_any
  );

endinterface
`default_nettype wire

// File: rtl/key_event_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_event_chan - one key: synchroniser, debounce FSM, long-press and repeat
// Revision: 1.0
// ----------------------------------------------------------------------------
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int DEB_TICKS      = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200,
  parameter bit KEY_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic key_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic posedge_o,
  output logic negedge_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DEB_W  = cnt_width(DEB_TICKS);
  localparam int HOLD_W = cnt_width(LONG_TICKS);
  localparam int REP_W  = cnt_width(REPEAT_TICKS - 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 1);

  logic              sync1_q, sync2_q;
  key_state_t        state_q;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [REP_W-1:0]  rep_cnt_q;
  logic              level_q, pos_q, neg_q, long_q, rep_q;
  logic              pressed;

  assign pressed = sync2_q ^ KEY_ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= KEY_ACTIVE_LOW;
      sync2_q    <= KEY_ACTIVE_LOW;
      state_q    <= ST_RELEASED;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      level_q    <= 1'b0;
      pos_q      <= 1'b0;
      neg_q      <= 1'b0;
      long_q     <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      case (state_q)
        ST_RELEASED: begin
          if (pressed) begin
            state_q   <= ST_PRESS_CHK;
            deb_cnt_q <= '0;
          end
        end
        ST_PRESS_CHK: begin
          if (!pressed) begin
            state_q <= ST_RELEASED;
          end else if (tick_i) begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
            if (deb_cnt_q == DEB_LAST) begin
              state_q    <= ST_HELD;
              level_q    <= 1'b1;
              pos_q      <= 1'b1;
              hold_cnt_q <= '0;
              rep_cnt_q  <= '0;
            end
          end
        end
        ST_HELD: begin
          if (!pressed) begin
            state_q   <= ST_RELEASE_CHK;
            deb_cnt_q <= '0;
          end else if (tick_i) begin
            // Repeat counting only starts on the tick after the long pulse.
            if (hold_cnt_q != HOLD_MAX) begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
              long_q     <= (hold_cnt_q == HOLD_LAST);
            end else if (rep_cnt_q == REP_LAST) begin
              rep_cnt_q <= '0;
              rep_q     <= repeat_en_i;
            end else begin
              rep_cnt_q <= rep_cnt_q + 1'b1;
            end
          end
        end
        ST_RELEASE_CHK: begin
          if (pressed) begin
            state_q <= ST_HELD;
          end else if (tick_i) begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
            if (deb_cnt_q == DEB_LAST) begin
              state_q <= ST_RELEASED;
              level_q <= 1'b0;
              neg_q   <= 1'b1;
            end
          end
        end
        default: state_q <= ST_RELEASED;
      endcase
    end
  end

  assign level_o   = level_q;
  assign posedge_o = pos_q;
  assign negedge_o = neg_q;
  assign long_o    = long_q;
  assign repeat_o  = rep_q;

endmodule
`default_nettype wire

// File: rtl/key_event_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_event_bank - N_KEYS key conditioners sharing one free-running tick
// Revision: 1.0
// ----------------------------------------------------------------------------
module key_event_bank
  import key_event_pkg::*;
#(
  parameter int N_KEYS         = 8,
  parameter int TICK_DIV       = 100000,
  parameter int DEB_TICKS      = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200,
  parameter bit KEY_ACTIVE_LOW = 1'b0
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  key_event_bank_if.slave bus
);

  localparam int                TICK_W    = cnt_width(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [N_KEYS-1:0] level, pos, neg, lng, rep;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_event_chan #(
      .DEB_TICKS      (DEB_TICKS),
      .LONG_TICKS     (LONG_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_chan (
      .clk         (sys_clk),
      .rst_n       (sys_rst_n),
      .tick_i      (tick),
      .key_i       (bus.key_in[i]),
      .repeat_en_i (bus.repeat_en[i]),
      .level_o     (level[i]),
      .posedge_o   (pos[i]),
      .negedge_o   (neg[i]),
      .long_o      (lng[i]),
      .repeat_o    (rep[i])
    );
  end

  assign bus.key_level   = level;
  assign bus.key_posedge = pos;
  assign bus.key_negedge = neg;
  assign bus.key_long    = lng;
  assign bus.key_repeat  = rep;
  assign bus.key_any     = |level;

endmodule
`default_nettype wire
